// File: rtl/data_bus_bridge_if.sv
// Core load/store port and peripheral posted-write bus of data_bus_bridge.
// master = core + peripheral responder side, slave = bridge side.
interface data_bus_bridge_if;
    logic [31:0] dataMemRAddr;
    logic [31:0] dataMemWData;
    logic        dataMem_wr_en;
    logic [31:0] dataMemRData;
    logic        pbus_valid;
    logic [31:0] pbus_addr;
    logic [31:0] pbus_wdata;
    logic        pbus_ready;

    modport master (
        output dataMemRAddr, dataMemWData, dataMem_wr_en, pbus_ready,
        input  dataMemRData, pbus_valid, pbus_addr, pbus_wdata
    );

    modport slave (
        input  dataMemRAddr, dataMemWData, dataMem_wr_en, pbus_ready,
        output dataMemRData, pbus_valid, pbus_addr, pbus_wdata
    );
endinterface

// File: rtl/data_bus_bridge.sv
// Core data-port decoder: word RAM, posted-write peripheral FIFO and status register.
// Optional head-of-queue stall timeout enabled by defining DATA_BUS_TIMEOUT_EN.
module data_bus_bridge #(
    parameter int unsigned RAM_DEPTH      = 256,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [31:0] STATUS_OFFSET  = 32'h0000_0FFC,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    data_bus_bridge_if.slave bus
);
    localparam int unsigned RAM_AW      = $clog2(RAM_DEPTH);
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] STATUS_ADDR = 32'h1000_0000 + STATUS_OFFSET;
    localparam logic [3:0]  REG_RAM     = 4'h0;
    localparam logic [3:0]  REG_PERIPH  = 4'h1;

    logic [31:0]       r_ram [RAM_DEPTH];
    logic [31:0]       r_fifo_addr [FIFO_DEPTH];
    logic [31:0]       r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;
    logic              r_overflow;

    logic [3:0]        w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_is_status;
    logic              w_periph_wr;
    logic              w_status_wr;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_to_fire;
    logic              w_timeout;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [31:0]       w_status;
    logic [31:0]       w_rdata;

    // Address decode
    assign w_region    = bus.dataMemRAddr[31:28];
    assign w_ram_idx   = bus.dataMemRAddr[RAM_AW+1:2];
    assign w_is_status = (w_region == REG_PERIPH) &&
                         (bus.dataMemRAddr[31:2] == STATUS_ADDR[31:2]);
    assign w_periph_wr = bus.dataMem_wr_en && (w_region == REG_PERIPH) && !w_is_status;
    assign w_status_wr = bus.dataMem_wr_en && w_is_status;

    // Acceptance depends only on registered fullness, never on pbus_ready
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = w_periph_wr && !w_full;
    assign w_ovf_set = w_periph_wr && w_full;
    assign w_pop     = !w_empty && (bus.pbus_ready || w_to_fire);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_status_wr && bus.dataMemWData[10]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Queue storage needs no reset; the head is masked while the queue is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.dataMemRAddr;
            r_fifo_data[r_wr_ptr] <= bus.dataMemWData;
        end
    end

`ifdef DATA_BUS_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    assign w_to_fire = !w_empty && !bus.pbus_ready &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_empty || w_pop) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_to_fire) begin
                r_timeout <= 1'b1;
            end else if (w_status_wr && bus.dataMemWData[11]) begin
                r_timeout <= 1'b0;
            end
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_to_fire            = 1'b0;
    assign w_timeout            = 1'b0;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign w_status = {20'h0_0000, w_timeout, r_overflow, w_empty, w_full, 8'(r_count)};

    // Data RAM: write at the edge, so a same-cycle read still returns old data
    always_ff @(posedge clk) begin
        if (bus.dataMem_wr_en && (w_region == REG_RAM)) begin
            r_ram[w_ram_idx] <= bus.dataMemWData;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_region == REG_RAM) begin
            w_rdata = r_ram[w_ram_idx];
        end else if (w_is_status) begin
            w_rdata = w_status;
        end
    end

    assign bus.dataMemRData = w_rdata;
    assign bus.pbus_valid   = r_valid;
    assign bus.pbus_addr    = r_valid ? r_fifo_addr[r_rd_ptr] : '0;
    assign bus.pbus_wdata   = r_valid ? r_fifo_data[r_rd_ptr] : '0;
endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed self-checking bench for data_bus_bridge (default parameters).
// Timeout expectations follow DATA_BUS_TIMEOUT_EN when it is defined for the build.
module tb_data_bus_bridge;
    localparam logic [31:0] STATUS = 32'h1000_0FFC;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    data_bus_bridge_if bus_if ();

    data_bus_bridge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus_if.dataMemRAddr  = a;
        bus_if.dataMemWData  = d;
        bus_if.dataMem_wr_en = 1'b1;
        cyc();
        bus_if.dataMem_wr_en = 1'b0;
        bus_if.dataMemWData  = '0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        bus_if.dataMem_wr_en = 1'b0;
        bus_if.dataMemRAddr  = a;
        #1;
        d = bus_if.dataMemRData;
    endtask

    initial begin
        logic [31:0] rd;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus_if.dataMemRAddr  = '0;
        bus_if.dataMemWData  = '0;
        bus_if.dataMem_wr_en = 1'b0;
        bus_if.pbus_ready    = 1'b0;
        repeat (2) cyc();
        chk("reset_valid", 32'(bus_if.pbus_valid), 32'h0);
        chk("reset_addr", bus_if.pbus_addr, 32'h0);
        chk("reset_wdata", bus_if.pbus_wdata, 32'h0);
        reset = 1'b0;
        load(STATUS, rd);
        chk("reset_status", rd, 32'h0000_0200);

        // RAM store/load, alias, read-during-write
        store(32'h0000_0010, 32'hDEAD_BEEF);
        load(32'h0000_0010, rd);
        chk("ram_load", rd, 32'hDEAD_BEEF);
        load(32'h0000_0410, rd);
        chk("ram_alias", rd, 32'hDEAD_BEEF);
        bus_if.dataMemRAddr  = 32'h0000_0010;
        bus_if.dataMemWData  = 32'h1234_5678;
        bus_if.dataMem_wr_en = 1'b1;
        #1;
        chk("ram_rdw_old", bus_if.dataMemRData, 32'hDEAD_BEEF);
        cyc();
        load(32'h0000_0010, rd);
        chk("ram_rdw_new", rd, 32'h1234_5678);

        // Unmapped and non-status peripheral accesses
        store(32'h2000_0000, 32'hFFFF_FFFF);
        chk("unmapped_no_push", 32'(bus_if.pbus_valid), 32'h0);
        load(32'h2000_0000, rd);
        chk("unmapped_read", rd, 32'h0);
        load(32'h1000_0004, rd);
        chk("periph_read", rd, 32'h0);
        load(STATUS, rd);
        chk("unmapped_status", rd, 32'h0000_0200);

        // Single posted write
        store(32'h1000_0004, 32'h0000_0055);
        chk("single_valid", 32'(bus_if.pbus_valid), 32'h1);
        chk("single_addr", bus_if.pbus_addr, 32'h1000_0004);
        chk("single_wdata", bus_if.pbus_wdata, 32'h0000_0055);
        load(STATUS, rd);
        chk("single_status", rd, 32'h0000_0001);
        bus_if.pbus_ready = 1'b1;
        cyc();
        bus_if.pbus_ready = 1'b0;
        chk("single_drained", 32'(bus_if.pbus_valid), 32'h0);
        load(STATUS, rd);
        chk("single_status_empty", rd, 32'h0000_0200);

        // Overflow: five stores into four entries, then W1C
        for (int i = 0; i < 5; i++) begin
            store(32'h1000_0000 + 32'(4 * i), 32'h0000_0100 + 32'(i));
        end
        load(STATUS, rd);
        chk("ovf_status", rd, 32'h0000_0504);
        chk("ovf_head_addr", bus_if.pbus_addr, 32'h1000_0000);
        chk("ovf_head_wdata", bus_if.pbus_wdata, 32'h0000_0100);
        store(STATUS, 32'h0000_0400);
        load(STATUS, rd);
        chk("ovf_w1c", rd, 32'h0000_0104);
        bus_if.pbus_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_addr", bus_if.pbus_addr, 32'h1000_0000 + 32'(4 * k));
            chk("drain_wdata", bus_if.pbus_wdata, 32'h0000_0100 + 32'(k));
            cyc();
        end
        bus_if.pbus_ready = 1'b0;
        chk("drain_dropped_fifth", 32'(bus_if.pbus_valid), 32'h0);
        load(STATUS, rd);
        chk("drain_status", rd, 32'h0000_0200);

        // Streaming with ready held high
        bus_if.pbus_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_if.dataMemRAddr  = 32'h1000_0100 + 32'(4 * i);
            bus_if.dataMemWData  = 32'h0000_00A0 + 32'(i);
            bus_if.dataMem_wr_en = 1'b1;
            #1;
            if (i == 0) begin
                chk("stream_idle", 32'(bus_if.pbus_valid), 32'h0);
            end else begin
                chk("stream_valid", 32'(bus_if.pbus_valid), 32'h1);
                chk("stream_addr", bus_if.pbus_addr, 32'h1000_0100 + 32'(4 * (i - 1)));
                chk("stream_wdata", bus_if.pbus_wdata, 32'h0000_00A0 + 32'(i - 1));
            end
            cyc();
        end
        load(STATUS, rd);
        chk("stream_status_last", rd, 32'h0000_0001);
        chk("stream_last_addr", bus_if.pbus_addr, 32'h1000_0114);
        cyc();
        load(STATUS, rd);
        chk("stream_status_end", rd, 32'h0000_0200);
        bus_if.pbus_ready = 1'b0;

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) begin
            store(32'h1000_0200 + 32'(4 * i), 32'h0000_0C00 + 32'(i));
        end
        bus_if.pbus_ready = 1'b1;
        cyc();
        load(STATUS, rd);
        chk("middrain_status", rd, 32'h0000_0002);
        chk("middrain_head", bus_if.pbus_addr, 32'h1000_0204);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus_if.pbus_ready = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus_if.pbus_valid), 32'h0);
        chk("rst_mid_addr", bus_if.pbus_addr, 32'h0);
        chk("rst_mid_wdata", bus_if.pbus_wdata, 32'h0);
        load(STATUS, rd);
        chk("rst_mid_status", rd, 32'h0000_0200);
        load(32'h0000_0010, rd);
        chk("rst_ram_kept", rd, 32'h1234_5678);

        // Stalled head: timeout drop when enabled, indefinite wait otherwise
        store(32'h1000_0300, 32'h0000_0777);
        bus_if.dataMemRAddr = STATUS;
        repeat (63) cyc();
        chk("stall_valid_64", 32'(bus_if.pbus_valid), 32'h1);
`ifdef DATA_BUS_TIMEOUT_EN
        cyc();
        chk("timeout_dropped", 32'(bus_if.pbus_valid), 32'h0);
        load(STATUS, rd);
        chk("timeout_status", rd, 32'h0000_0A00);
        store(STATUS, 32'h0000_0800);
        load(STATUS, rd);
        chk("timeout_w1c", rd, 32'h0000_0200);
`else
        repeat (200) cyc();
        chk("no_timeout_valid", 32'(bus_if.pbus_valid), 32'h1);
        load(STATUS, rd);
        chk("no_timeout_status", rd, 32'h0000_0001);
        store(STATUS, 32'h0000_0800);
        load(STATUS, rd);
        chk("no_timeout_w1c", rd, 32'h0000_0001);
        bus_if.pbus_ready = 1'b1;
        cyc();
        bus_if.pbus_ready = 1'b0;
        chk("no_timeout_drain", 32'(bus_if.pbus_valid), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
Data-side consumer of the CPU core's load/store port (dataMemRAddr / dataMemWData / dataMem_wr_en / dataMemRData). Decodes each access into on-chip word RAM, a posted-write peripheral region, or unmapped space. Peripheral writes are queued in a FIFO and drained over a valid/ready bus, so the single-cycle core never stalls. A status register at a fixed address lets software poll FIFO state.

Parameters:
RAM_DEPTH, 256, data RAM size in 32-bit words (power of 2)
FIFO_DEPTH, 4, posted-write FIFO entries (power of 2, 2..16)
STATUS_OFFSET, 32'h0000_0FFC, offset of the status register inside the peripheral region
TIMEOUT_CYCLES, 64, stall limit used only when DATA_BUS_TIMEOUT_EN is defined

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
dataMemRAddr  in  32  byte address from the core; bits [1:0] ignored, word access only
dataMemWData  in  32  store data from the core, already lane-aligned
dataMem_wr_en  in  1  store strobe from the core
dataMemRData  out  32  load data to the core, combinational from address
pbus_valid  out  1  peripheral write request valid (FIFO head present)
pbus_addr  out  32  peripheral write address (FIFO head)
pbus_wdata  out  32  peripheral write data (FIFO head)
pbus_ready  in  1  peripheral accepts the head entry this cycle

Behaviour:
- Clock and reset: single clock, clk; reset is synchronous and active-high; nothing is asynchronous.
- Address map (addr[31:28]):
  - 4'h0 = RAM, word index addr[log2(RAM_DEPTH)+1:2]; higher bits alias.
  - 4'h1 = peripheral region.
  - All other values unmapped: read 0, writes ignored.
- RAM:
  - Reads are combinational (same cycle as address).
  - Writes commit at the clk edge when dataMem_wr_en=1.
  - Read of the address being written in that cycle returns the old data.
  - Contents are not reset.
- Peripheral write (wr_en=1, region 4'h1, addr != 32'h1000_0000+STATUS_OFFSET):
  - Pushed as {addr, wdata} at the clk edge.
  - Peripheral-region reads other than status return 32'h0.
- Status register read value:
  - [7:0] = count
  - [8] = full
  - [9] = empty
  - [10] = overflow (sticky)
  - [11] = timeout (sticky)
  - remaining bits 0
- Status register write: W1C on bits [10] and [11]; other bits ignored. A status write is never pushed.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and count (0..FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH.
  - pbus_valid = (count != 0). pbus_addr and pbus_wdata come from the head entry and stay stable while valid=1 and ready=0.
  - Pop when pbus_valid && pbus_ready.
  - Push when the peripheral write condition holds && count < FIFO_DEPTH.
  - Push while full: dropped, overflow <= 1. This applies even if a pop happens in the same cycle, so there is no combinational path from pbus_ready to acceptance.
  - Push and pop in the same cycle with 0 < count < FIFO_DEPTH: count unchanged, both pointers advance.
  - Push into an empty FIFO at edge N: pbus_valid=1 during cycle N+1. Minimum latency is 1 cycle.
- Reset (mid-transfer included): wr_ptr=rd_ptr=count=0, overflow=0, timeout=0, timeout counter=0. Outputs: pbus_valid=0, pbus_addr=0, pbus_wdata=0. Queued entries are discarded.
- Unknown or unmapped accesses never change FIFO or flag state.

Optional Feature:
DATA_BUS_TIMEOUT_EN
- Defined:
  - A counter increments each cycle with pbus_valid=1 and pbus_ready=0.
  - It clears on pop, and on any cycle with valid=0.
  - When it reaches TIMEOUT_CYCLES-1 with ready still 0, the head entry is popped (discarded), timeout <= 1, and the counter clears.
- Not defined: no counter logic; the bridge waits for ready indefinitely; status bit [11] reads 0 and W1C on it has no effect.

Test Plan:
1. Store 32'hDEADBEEF to 0x0000_0010, then load 0x0000_0010 -> dataMemRData=32'hDEADBEEF. Load 0x0000_0410 (RAM_DEPTH=256 alias) -> same value.
2. Store 32'h55 to 0x1000_0004 with pbus_ready=0 -> next cycle pbus_valid=1, pbus_addr=0x1000_0004, pbus_wdata=0x55. Status read -> 32'h0000_0001. Raise ready for 1 cycle -> valid=0, status=32'h0000_0200.
3. With ready=0, issue 5 stores to 0x1000_0000..0x1000_0010 -> the first 4 are queued; status=32'h0000_0504 (count 4, full, overflow). Write 32'h400 to 0x1000_0FFC -> status=32'h0000_0104.
4. Hold ready=1 while storing every cycle -> each entry appears 1 cycle after its store, in order; count never exceeds 1; overflow stays 0.
5. Fill 3 entries, assert reset for 1 cycle mid-drain -> next cycle pbus_valid=0, status=32'h0000_0200. Earlier RAM data is still readable.
6. With DATA_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=64, one entry and ready=0 -> after 64 valid cycles the entry is dropped, valid=0, status bit 11=1. Without the macro: valid stays 1 after 200 cycles.
